// File: rtl/pipe_reg.sv
// Elastic register pipeline of DEPTH stages with bubble collapse, flush and occupancy count.
// Define PIPE_REG_STALL_CNT_EN to add a saturating 16-bit output-stall counter (stall_cnt).
module pipe_reg #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    occupancy
`ifdef PIPE_REG_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   logic [DEPTH-1:0] stageValid;
   logic [DEPTH-1:0] stageAccept;
   logic [DEPTH-1:0] feedValid;
   logic [DEPTH-1:0] nextValid;
   logic [WIDTH-1:0] stageData [DEPTH];
   logic [WIDTH-1:0] feedData  [DEPTH];
   logic [CW-1:0]    occCount;

   function automatic logic [CW-1:0] countValid(input logic [DEPTH-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int k = 0; k < DEPTH; k++) begin
         n = n + CW'(v[k]);
      end
      return n;
   endfunction

   // A stage can take a new entry if it is empty or everything below it moves on.
   always_comb begin
      logic chain;
      stageAccept = '0;
      chain       = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         chain          = !stageValid[k] | chain;
         stageAccept[k] = chain;
      end
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : gFeed
         if (g == 0) begin : gHead
            assign feedValid[g] = in_valid;
            assign feedData[g]  = in_data;
         end else begin : gBody
            assign feedValid[g] = stageValid[g-1];
            assign feedData[g]  = stageData[g-1];
         end
      end
   endgenerate

   always_comb begin
      nextValid = stageValid;
      if (flush) begin
         nextValid = '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (stageAccept[k]) begin
               nextValid[k] = feedValid[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stageValid <= '0;
         occCount   <= '0;
      end else begin
         stageValid <= nextValid;
         occCount   <= countValid(nextValid);
      end
   end

   // Payload registers only move for real entries, and flush leaves them untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stageData[k] <= '0;
         end
      end else if (!flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (stageAccept[k] && feedValid[k]) begin
               stageData[k] <= feedData[k];
            end
         end
      end
   end

   assign in_ready  = stageAccept[0];
   assign out_valid = stageValid[DEPTH-1];
   assign out_data  = stageData[DEPTH-1];
   assign occupancy = occCount;

`ifdef PIPE_REG_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   occBounded: assert property (@(posedge clk) disable iff (!rst_n)
      occCount <= CW'(DEPTH));

   occMatchesValid: assert property (@(posedge clk) disable iff (!rst_n)
      occCount == countValid(stageValid));

   stallHoldsOutput: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of register stages (legal range 1..8).
REQ-003 SHALL have parameter CW, default $clog2(DEPTH+1), meaning occupancy counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  last stage holds an entry.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  last-stage payload.
REQ-013 SHALL have port occupancy  output  CW  count of valid stages.

Function
REQ-014 SHALL hold per stage k (0..DEPTH-1) a valid bit v[k] and data register d[k]; out_valid = v[DEPTH-1], out_data = d[DEPTH-1].
REQ-015 SHALL compute acceptance combinationally: acc[DEPTH-1] = !v[DEPTH-1] | out_ready; acc[k] = !v[k] | acc[k+1] for k < DEPTH-1; in_ready = acc[0].
REQ-016 SHALL on a clock edge where acc[k] is 1 load stage k from stage k-1 (or from in_valid/in_data for k=0): v[k] <= v[k-1], d[k] <= d[k-1].
REQ-017 SHALL hold v[k] and d[k] unchanged when acc[k] is 0 (stall); no entry is lost or duplicated.
REQ-018 SHALL collapse bubbles: an empty stage accepts even when downstream is stalled.
REQ-019 SHALL give latency of exactly DEPTH cycles from in_valid&in_ready to out_valid when out_ready stays 1; throughput 1 entry/cycle.
REQ-020 SHALL transfer upstream only on in_valid & in_ready and downstream only on out_valid & out_ready.
REQ-021 SHALL load d[k] only when the incoming valid is 1; an invalid slot leaves d[k] unchanged.
REQ-022 SHALL on flush=1 clear every v[k] at the next edge, ignore in_valid that cycle, and leave d[k] unchanged; flush overrides all other updates.
REQ-023 SHALL keep in_ready driven per REQ-015 during flush (an accepted-looking handshake in that cycle is discarded).
REQ-024 SHALL drive occupancy as the registered population count of v[], range 0..DEPTH, updated the same edge as v[].
REQ-025 SHALL, when full (occupancy = DEPTH) with out_ready=0, drive in_ready=0; with out_ready=1 drive in_ready=1 (simultaneous pop and push).

Reset
REQ-026 SHALL on rst_n=0 asynchronously clear all v[k] to 0, all d[k] to 0, occupancy to 0, stall_cnt (if present) to 0.
REQ-027 SHALL discard any entry in flight when reset asserts mid-operation; first acceptance is on the first edge after rst_n rises.
REQ-028 SHALL drive in_ready=1 and out_valid=0 throughout reset.

Configuration
REQ-029 SHALL, when macro PIPE_REG_STALL_CNT_EN is defined, add output stall_cnt (16 bits) counting edges with out_valid=1 and out_ready=0, saturating at 16'hFFFF, cleared by reset only (not by flush).
REQ-030 SHALL, when PIPE_REG_STALL_CNT_EN is undefined, have no stall_cnt port or logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover streaming: DEPTH=2, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 2,3,4, occupancy stays 2 mid-stream.
REQ-032 SHALL cover backpressure: DEPTH=2, out_ready=0, push 0xA,0xB,0xC -> in_ready falls after 2 accepts, occupancy=2; release out_ready -> 0xA then 0xB out, 0xC accepted, no loss.
REQ-033 SHALL cover bubble collapse: DEPTH=3, push 0x5 then idle 1 cycle with out_ready=0 -> 0x5 reaches stage 2, in_ready stays 1 until occupancy=3.
REQ-034 SHALL cover flush: occupancy=2, flush=1 with in_valid=1, in_data=0x77 -> next cycle occupancy=0, out_valid=0, 0x77 never emerges.
REQ-035 SHALL cover mid-operation reset: occupancy=2, drop rst_n between edges -> out_valid=0, out_data=0 immediately, in_ready=1.
REQ-036 SHALL cover stall counter with PIPE_REG_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush leaves it at 5.
